// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction-memory and IR handshake bundle for fetch_sequencer
//
// Signals:
//   mem_addr  : fetch address to instruction memory
//   mem_req   : fetch request qualifier
//   mem_rdata : instruction word returned by memory
//   ir        : latched instruction offered to the control unit
//   ir_pc     : address the offered instruction came from
//   ir_valid  : ir holds an undelivered instruction
//   ir_ready  : control unit accepts ir this cycle
// Modports: master = sequencer side, slave = memory/control-unit side.
interface fetch_sequencer_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_req;
    logic [INSTR_W-1:0] mem_rdata;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  ir_pc;
    logic               ir_valid;
    logic               ir_ready;

    modport master (
        output mem_addr, mem_req, ir, ir_pc, ir_valid,
        input  mem_rdata, ir_ready
    );

    modport slave (
        input  mem_addr, mem_req, ir, ir_pc, ir_valid,
        output mem_rdata, ir_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multicycle instruction-fetch controller with redirect and halt
//
// Ports:
//   clk            : clock, all state updates on rising edge
//   reset          : synchronous active-high reset
//   bus            : fetch_sequencer_if.master (memory address/request/data, IR valid/ready)
//   redirect_valid : load redirect_pc and discard any in-flight or held fetch
//   redirect_pc    : redirect target
//   halt           : stop issuing new fetches
//   pc             : current fetch PC
//   halted         : sequencer is parked in HALTED
//   fetch_count    : completed IR handshakes, wraps
module fetch_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int INSTR_W     = 16,
    parameter int MEM_LATENCY = 0,
    parameter int RESET_PC    = 0,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    fetch_sequencer_if.master   bus,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic                halt,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted,
    output logic [CNT_W-1:0]    fetch_count
);

    // Wait counter only needs to reach MEM_LATENCY; keep at least one bit.
    localparam int WAIT_W = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
    localparam logic [WAIT_W-1:0] LAT_LAST  = WAIT_W'(MEM_LATENCY);
    localparam logic [ADDR_W-1:0] PC_RESET  = ADDR_W'(RESET_PC);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
    logic                ir_valid_q, ir_valid_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                halted_q, halted_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= PC_RESET;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            count_q    <= '0;
            wait_q     <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            count_q    <= count_d;
            wait_q     <= wait_d;
            halted_q   <= halted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        count_d    = count_q;
        wait_d     = wait_q;

        if (redirect_valid) begin
            // Redirect wins over a same-cycle handshake and over halt; the
            // held word is dropped without being counted.
            pc_d       = redirect_pc;
            ir_valid_d = 1'b0;
            wait_d     = '0;
            state_d    = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    // halt is only honoured before the memory access starts.
                    if (wait_q == '0 && halt) begin
                        state_d = ST_HALTED;
                    end else if (wait_q == LAT_LAST) begin
                        ir_d       = bus.mem_rdata;
                        ir_pc_d    = pc_q;
                        ir_valid_d = 1'b1;
                        pc_d       = pc_q + ADDR_W'(1);
                        wait_d     = '0;
                        state_d    = ST_HOLD;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (ir_valid_q && bus.ir_ready) begin
                        ir_valid_d = 1'b0;
                        count_d    = count_q + CNT_W'(1);
                        state_d    = halt ? ST_HALTED : ST_FETCH;
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end

        halted_d = (state_d == ST_HALTED);
    end

    assign bus.mem_addr = pc_q;
    assign bus.mem_req  = (state_q == ST_FETCH) && !reset;
    assign bus.ir       = ir_q;
    assign bus.ir_pc    = ir_pc_q;
    assign bus.ir_valid = ir_valid_q;

    assign pc          = pc_q;
    assign halted      = halted_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer (latency 0 and 2)
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        ir_ready;

    logic [15:0] pc0, pc2;
    logic        halted0, halted2;
    logic [15:0] cnt0, cnt2;

    int errors = 0;
    int checks = 0;

    fetch_sequencer_if #(.ADDR_W(16), .INSTR_W(16)) if0 ();
    fetch_sequencer_if #(.ADDR_W(16), .INSTR_W(16)) if2 ();

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: mem_word = 16'h00A3;
            16'h0001: mem_word = 16'hA032;
            16'h0002: mem_word = 16'h9036;
            16'hFFFF: mem_word = 16'hBEEF;
            default:  mem_word = a ^ 16'h5A5A;
        endcase
    endfunction

    assign if0.mem_rdata = mem_word(if0.mem_addr);
    assign if0.ir_ready  = ir_ready;
    assign if2.mem_rdata = mem_word(if2.mem_addr);
    assign if2.ir_ready  = ir_ready;

    fetch_sequencer #(
        .ADDR_W(16), .INSTR_W(16), .MEM_LATENCY(0), .RESET_PC(0), .CNT_W(16)
    ) u0 (
        .clk(clk), .reset(reset), .bus(if0.master),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .pc(pc0), .halted(halted0), .fetch_count(cnt0)
    );

    fetch_sequencer #(
        .ADDR_W(16), .INSTR_W(16), .MEM_LATENCY(2), .RESET_PC(0), .CNT_W(16)
    ) u2 (
        .clk(clk), .reset(reset), .bus(if2.master),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .pc(pc2), .halted(halted2), .fetch_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        halt           = 1'b0;
        ir_ready       = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst pc",       pc0, 0);
        chk("rst ir_valid", if0.ir_valid, 0);
        chk("rst ir",       if0.ir, 0);
        chk("rst ir_pc",    if0.ir_pc, 0);
        chk("rst count",    cnt0, 0);
        chk("rst halted",   halted0, 0);
        chk("rst mem_req",  if0.mem_req, 0);

        // Streaming at latency 0, ir_ready high.
        reset = 1'b0;
        #1;
        chk("A mem_req", if0.mem_req, 1);
        @(negedge clk);
        chk("A1 valid", if0.ir_valid, 1);
        chk("A1 ir",    if0.ir, 16'h00A3);
        chk("A1 ir_pc", if0.ir_pc, 0);
        chk("A1 pc",    pc0, 1);
        @(negedge clk);
        chk("A2 valid", if0.ir_valid, 0);
        chk("A2 count", cnt0, 1);
        chk("A2 addr",  if0.mem_addr, 1);
        @(negedge clk);
        chk("A3 valid", if0.ir_valid, 1);
        chk("A3 ir",    if0.ir, 16'hA032);
        chk("A3 ir_pc", if0.ir_pc, 1);
        @(negedge clk);
        chk("A4 valid", if0.ir_valid, 0);
        @(negedge clk);
        chk("A5 ir",    if0.ir, 16'h9036);
        chk("A5 ir_pc", if0.ir_pc, 2);
        chk("A5 valid", if0.ir_valid, 1);
        @(negedge clk);
        chk("A6 count", cnt0, 3);

        // Backpressure.
        reset    = 1'b1;
        ir_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("B valid", if0.ir_valid, 1);
        repeat (5) @(negedge clk);
        chk("B hold ir",    if0.ir, 16'h00A3);
        chk("B hold pc",    pc0, 1);
        chk("B hold req",   if0.mem_req, 0);
        chk("B hold count", cnt0, 0);
        chk("B hold valid", if0.ir_valid, 1);
        ir_ready = 1'b1;
        @(negedge clk);
        chk("B count", cnt0, 1);
        chk("B addr",  if0.mem_addr, 1);
        chk("B req",   if0.mem_req, 1);
        ir_ready = 1'b0;
        @(negedge clk);
        chk("B2 ir", if0.ir, 16'hA032);

        // Redirect in HOLD with ir_ready high the same cycle.
        ir_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0010;
        @(negedge clk);
        chk("C valid", if0.ir_valid, 0);
        chk("C count", cnt0, 1);
        chk("C pc",    pc0, 16'h0010);
        chk("C addr",  if0.mem_addr, 16'h0010);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("C ir_pc", if0.ir_pc, 16'h0010);
        chk("C ir",    if0.ir, 16'h5A4A);

        // halt during HOLD, then handshake.
        reset    = 1'b1;
        ir_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        halt     = 1'b1;
        ir_ready = 1'b1;
        @(negedge clk);
        chk("D halted", halted0, 1);
        chk("D count",  cnt0, 1);
        chk("D valid",  if0.ir_valid, 0);
        chk("D req",    if0.mem_req, 0);
        halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("D stay halted", halted0, 1);
            chk("D stay req",    if0.mem_req, 0);
        end
        chk("D pc", pc0, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0005;
        @(negedge clk);
        chk("D exit halted", halted0, 0);
        chk("D exit req",    if0.mem_req, 1);
        chk("D exit addr",   if0.mem_addr, 16'h0005);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("D ir_pc", if0.ir_pc, 16'h0005);
        chk("D ir",    if0.ir, 16'h5A5F);

        // PC wrap.
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        @(negedge clk);
        chk("E pc", pc0, 16'hFFFF);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("E ir_pc", if0.ir_pc, 16'hFFFF);
        chk("E ir",    if0.ir, 16'hBEEF);
        chk("E wrap",  pc0, 16'h0000);

        // Latency 2 DUT.
        reset    = 1'b1;
        ir_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("F1 valid", if2.ir_valid, 0);
        chk("F1 req",   if2.mem_req, 1);
        chk("F1 addr",  if2.mem_addr, 0);
        @(negedge clk);
        chk("F2 valid", if2.ir_valid, 0);
        @(negedge clk);
        chk("F3 valid", if2.ir_valid, 1);
        chk("F3 ir",    if2.ir, 16'h00A3);
        chk("F3 ir_pc", if2.ir_pc, 0);
        chk("F3 pc",    pc2, 1);
        @(negedge clk);
        chk("F4 valid", if2.ir_valid, 0);
        chk("F4 count", cnt2, 1);
        chk("F4 addr",  if2.mem_addr, 1);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        @(negedge clk);
        chk("F6 pc",    pc2, 16'h0040);
        chk("F6 addr",  if2.mem_addr, 16'h0040);
        chk("F6 valid", if2.ir_valid, 0);
        chk("F6 count", cnt2, 1);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("F7 valid", if2.ir_valid, 0);
        @(negedge clk);
        chk("F8 valid", if2.ir_valid, 0);
        @(negedge clk);
        chk("F9 valid", if2.ir_valid, 1);
        chk("F9 ir_pc", if2.ir_pc, 16'h0040);
        chk("F9 ir",    if2.ir, 16'h5A1A);

        // Reset mid-FETCH.
        @(negedge clk);
        chk("G count", cnt2, 2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("G pc",     pc2, 0);
        chk("G ir",     if2.ir, 0);
        chk("G ir_pc",  if2.ir_pc, 0);
        chk("G valid",  if2.ir_valid, 0);
        chk("G count",  cnt2, 0);
        chk("G halted", halted2, 0);
        chk("G req",    if2.mem_req, 0);
        chk("G addr",   if2.mem_addr, 0);

        // halt on FETCH entry.
        halt = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("H halted", halted2, 1);
        chk("H pc",     pc2, 0);
        chk("H valid",  if2.ir_valid, 0);
        chk("H req",    if2.mem_req, 0);
        halt = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multicycle instruction-fetch controller between the PC and the word-addressed instruction memory.
- Owns the PC, presents fetch addresses, waits a fixed memory latency, latches the word into an instruction register (IR), and hands it to the control unit over a valid/ready handshake.
- Supports redirect (branch/jump) and halt.
- Memory side: instruction memory with 16-bit address in, 16-bit instruction out.

Parameters:
ADDR_W, 16, PC/memory address width
INSTR_W, 16, instruction width
MEM_LATENCY, 0, cycles between mem_addr stable and mem_rdata valid (0 = combinational read)
RESET_PC, 0, PC value loaded on reset
CNT_W, 16, width of delivered-instruction counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
mem_addr  out  ADDR_W  fetch address to instruction memory; equals pc
mem_req  out  1  high while in FETCH state and reset low
mem_rdata  in  INSTR_W  instruction word from memory
ir  out  INSTR_W  latched instruction
ir_pc  out  ADDR_W  address ir was fetched from
ir_valid  out  1  ir holds an undelivered instruction
ir_ready  in  1  control unit accepts ir this cycle
redirect_valid  in  1  load new PC, discard in-flight/held fetch
redirect_pc  in  ADDR_W  redirect target
halt  in  1  stop issuing new fetches
pc  out  ADDR_W  current fetch PC
halted  out  1  high in HALTED state
fetch_count  out  CNT_W  number of completed handshakes, wraps modulo 2^CNT_W

Behaviour:
- Reset (sync, priority over everything):
  - pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, fetch_count=0, wait counter=0, state=FETCH, halted=0.
  - mem_req forced 0 while reset high.
  - Reset mid-fetch or mid-hold drops everything; no handshake is counted.
- States: FETCH, HOLD, HALTED.
- FETCH:
  - mem_addr=pc, mem_req=1. Wait counter increments each cycle.
  - On the cycle where counter==MEM_LATENCY: ir<=mem_rdata, ir_pc<=pc, ir_valid<=1, pc<=pc+1 (wraps modulo 2^ADDR_W), counter<=0, go HOLD.
  - Fetch latency is MEM_LATENCY+1 cycles from FETCH entry to ir_valid high.
  - If halt=1 on FETCH entry cycle (counter==0): go HALTED, no capture, pc unchanged.
  - Once counter>0, halt is ignored until the fetch completes.
- HOLD:
  - ir, ir_pc, ir_valid held stable while ir_ready=0.
  - Handshake = ir_valid & ir_ready: ir_valid<=0, fetch_count<=fetch_count+1, next state HALTED if halt=1, else FETCH.
  - Throughput with ir_ready tied high: one instruction per MEM_LATENCY+2 cycles.
- HALTED:
  - mem_req=0, halted=1, pc held.
  - Exits only on redirect_valid or reset; dropping halt alone does not resume.
- Redirect (priority below reset, above all else, any state):
  - pc<=redirect_pc, ir_valid<=0, counter<=0, state<=FETCH.
  - A held ir is discarded even if ir_ready=1 the same cycle; no handshake is counted.
  - halt in the same cycle is ignored; halt is re-evaluated on FETCH entry.
- Outputs ir, ir_pc, ir_valid, pc, halted, fetch_count are registered. mem_req and mem_addr are decoded from state/pc.
- mem_rdata is sampled only on the capture cycle; its value on other cycles is don't-care.

Test Plan:
- MEM_LATENCY=0, memory words 0x00A3, 0xA032, 0x9036 at 0..2, ir_ready=1, release reset: ir_valid pulses carry ir=0x00A3/ir_pc=0, then 0xA032/1, then 0x9036/2, one every 2 cycles; fetch_count=3 after the third handshake.
- Backpressure: hold ir_ready=0 for 5 cycles after the first ir_valid -> ir stays 0x00A3, pc=1, mem_req=0, fetch_count=0; assert ir_ready -> count=1, mem_addr=1 the next cycle.
- MEM_LATENCY=2 -> ir_valid rises exactly 3 cycles after FETCH entry. Pulse redirect_valid with redirect_pc=0x0040 at wait count 1 -> fetch restarts, mem_addr=0x0040, ir_pc=0x0040 on the next delivery, no stale word delivered.
- Redirect in HOLD with ir_ready=1 the same cycle -> ir_valid drops, fetch_count unchanged, pc=redirect_pc.
- halt=1 during HOLD, then handshake -> HALTED, halted=1, mem_req=0 for 10 cycles even after halt drops. redirect_valid to 0x0005 -> FETCH at 5.
- pc=0xFFFF fetch -> ir_pc=0xFFFF, pc wraps to 0x0000. Assert reset mid-FETCH with MEM_LATENCY=2 -> next cycle all outputs at reset values, mem_addr=RESET_PC.
